// File: rtl/ysyx_23060201_ctrl.sv
// Multi-cycle processor control FSM: sequences fetch, decode, execute,
// memory access and write-back. It also tracks cycle and retired-instruction
// counts, and bounds how long it waits on the fetch and load/store units.
module ysyx_23060201_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  input  logic        ifu_valid,
  input  logic [6:0]  inst_op,
  input  logic [2:0]  inst_func3,
  output logic        ir_wen,
  output logic        lsu_req,
  output logic        lsu_wen,
  input  logic        lsu_done,
  output logic        gpr_wen,
  output logic        pc_wen,
  output logic        halt,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [2:0]  state,
  output logic [31:0] cyc_cnt,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_IL  = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_U   = 7'b0110111;
  localparam logic [6:0] OP_UPC = 7'b0010111;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  localparam logic [1:0] EC_ILLEGAL = 2'b01;
  localparam logic [1:0] EC_FETCH   = 2'b10;
  localparam logic [1:0] EC_LSU     = 2'b11;

  localparam int unsigned WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [WW:0]   wait_inc;
  logic          wait_expired;
  logic [31:0]   cyc_q, cyc_d;
  logic [31:0]   instret_q, instret_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          ifu_req_q, ifu_req_d;
  logic          lsu_req_q, lsu_req_d;
  logic          lsu_wen_q, lsu_wen_d;
  logic          gpr_wen_q, gpr_wen_d;
  logic          pc_wen_q, pc_wen_d;
  logic          halt_q, halt_d;
  logic          err_q, err_d;

  logic op_legal, op_mem, op_store, op_writes_rd;

  // Opcode classification of the instruction currently held in the IR.
  always_comb begin
    op_legal     = 1'b0;
    op_writes_rd = 1'b0;
    case (inst_op)
      OP_R, OP_I, OP_IL, OP_U, OP_UPC, OP_J, OP_JR: begin
        op_legal     = 1'b1;
        op_writes_rd = 1'b1;
      end
      OP_S, OP_B, OP_SYS: op_legal = 1'b1;
      default: ;
    endcase
    op_mem   = (inst_op == OP_IL) || (inst_op == OP_S);
    op_store = (inst_op == OP_S);
  end

  // Wait-cycle accounting: the count reaching the limit without a response
  // is a timeout. A response in that same cycle takes priority.
  always_comb begin
    wait_inc     = {1'b0, wait_q} + {{WW{1'b0}}, 1'b1};
    wait_expired = (32'(wait_inc) >= MEM_TIMEOUT);
  end

  // Next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    err_code_d = err_code_q;
    cyc_d      = cyc_q + 32'd1;
    instret_d  = instret_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        if (ifu_valid) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d    = S_ERR;
          err_code_d = EC_FETCH;
        end else begin
          wait_d = wait_inc[WW-1:0];
        end
      end
      S_DECODE: begin
        if (!op_legal || ((inst_op == OP_SYS) && (inst_func3 != 3'b000))) begin
          state_d    = S_ERR;
          err_code_d = EC_ILLEGAL;
        end else if (inst_op == OP_SYS) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_mem) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (lsu_done) begin
          state_d = S_WB;
        end else if (wait_expired) begin
          state_d    = S_ERR;
          err_code_d = EC_LSU;
        end else begin
          wait_d = wait_inc[WW-1:0];
        end
      end
      S_WB: begin
        state_d   = S_FETCH;
        wait_d    = '0;
        instret_d = instret_q + 32'd1;
      end
      S_HALT: state_d = S_HALT;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    // Moore outputs are registered from the next state so they line up
    // exactly with the state they belong to.
    ifu_req_d = (state_d == S_FETCH);
    lsu_req_d = (state_d == S_MEM);
    lsu_wen_d = (state_d == S_MEM) && op_store;
    gpr_wen_d = (state_d == S_WB) && op_writes_rd;
    pc_wen_d  = (state_d == S_WB);
    halt_d    = (state_d == S_HALT);
    err_d     = (state_d == S_ERR);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      cyc_q      <= '0;
      instret_q  <= '0;
      err_code_q <= '0;
      ifu_req_q  <= 1'b0;
      lsu_req_q  <= 1'b0;
      lsu_wen_q  <= 1'b0;
      gpr_wen_q  <= 1'b0;
      pc_wen_q   <= 1'b0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      cyc_q      <= cyc_d;
      instret_q  <= instret_d;
      err_code_q <= err_code_d;
      ifu_req_q  <= ifu_req_d;
      lsu_req_q  <= lsu_req_d;
      lsu_wen_q  <= lsu_wen_d;
      gpr_wen_q  <= gpr_wen_d;
      pc_wen_q   <= pc_wen_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
    end
  end

  // The IR load strobe follows ifu_valid in the same cycle; it is suppressed during reset.
  always_comb begin
    ir_wen = !rst && (state_q == S_FETCH) && ifu_valid;
  end

  assign ifu_req  = ifu_req_q;
  assign lsu_req  = lsu_req_q;
  assign lsu_wen  = lsu_wen_q;
  assign gpr_wen  = gpr_wen_q;
  assign pc_wen   = pc_wen_q;
  assign halt     = halt_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign state    = state_q;
  assign cyc_cnt  = cyc_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_ysyx_23060201_ctrl.sv
// Self-checking bench for ysyx_23060201_ctrl. It builds the expected cycle
// sequence of each instruction from fetch and memory latencies, then replays
// it against the DUT.
module tb_ysyx_23060201_ctrl;
  localparam int unsigned T = 4;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3;
  localparam logic [2:0] MEM = 3'd4, WB = 3'd5, HALT = 3'd6, ERR = 3'd7;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_IL = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011, OP_B = 7'b1100011, OP_U = 7'b0110111;
  localparam logic [6:0] OP_UPC = 7'b0010111, OP_J = 7'b1101111, OP_JR = 7'b1100111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ifu_req, ifu_valid = 1'b0, ir_wen, lsu_req, lsu_wen, lsu_done = 1'b0;
  logic gpr_wen, pc_wen, halt, err;
  logic [6:0] inst_op = '0;
  logic [2:0] inst_func3 = '0;
  logic [1:0] err_code;
  logic [2:0] state;
  logic [31:0] cyc_cnt, instret;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] m_cyc, m_ret;
  logic [1:0]  m_code;

  typedef struct { logic [2:0] st; bit resp; } step_t;

  always #5 clk = ~clk;

  ysyx_23060201_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_valid(ifu_valid),
    .inst_op(inst_op), .inst_func3(inst_func3), .ir_wen(ir_wen),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_done(lsu_done),
    .gpr_wen(gpr_wen), .pc_wen(pc_wen), .halt(halt), .err(err),
    .err_code(err_code), .state(state), .cyc_cnt(cyc_cnt), .instret(instret)
  );

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_IL, OP_S, OP_B, OP_U, OP_UPC, OP_J, OP_JR, OP_SYS};
  endfunction

  function automatic bit writes_rd(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_IL, OP_U, OP_UPC, OP_J, OP_JR};
  endfunction

  // Expected {ifu_req, lsu_req, lsu_wen, gpr_wen, pc_wen, halt, err}
  function automatic logic [6:0] exp_out(input logic [2:0] st, input logic [6:0] op);
    case (st)
      FETCH:   return 7'b1000000;
      MEM:     return {1'b0, 1'b1, op == OP_S, 4'b0000};
      WB:      return {3'b000, writes_rd(op), 1'b1, 2'b00};
      HALT:    return 7'b0000010;
      ERR:     return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic do_reset(input string nm);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      ifu_valid = 1'($urandom % 2);
      lsu_done  = 1'($urandom % 2);
      #1;
      n_cmp++;
      if (ir_wen !== 1'b0) begin
        n_bad++; $display("FAIL %s ir_wen_in_reset: got %b want 0", nm, ir_wen);
      end
      @(posedge clk); #2;
      n_cmp++;
      if ({state, ifu_req, lsu_req, lsu_wen, gpr_wen, pc_wen, halt, err, err_code, cyc_cnt, instret}
          !== {IDLE, 7'b0, 2'b00, 32'd0, 32'd0}) begin
        n_bad++;
        $display("FAIL %s reset_vals: got st=%0d outs=%b code=%b cyc=%0d ret=%0d want all zero",
                 nm, state, {ifu_req, lsu_req, lsu_wen, gpr_wen, pc_wen, halt, err}, err_code, cyc_cnt, instret);
      end
    end
    rst = 1'b0; ifu_valid = 1'b0; lsu_done = 1'b0;
    @(posedge clk); #2;
    m_cyc = 32'd1; m_ret = '0; m_code = '0;
  endtask

  // Runs one instruction from its first FETCH cycle. fate: 0 retired, 1 halt, 2 error, 3 aborted.
  task automatic exec_inst(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input int unsigned flat, input int unsigned mlat,
                           input int abort_at, output int fate);
    step_t q[$];
    step_t s;
    logic [2:0] fin;
    logic [1:0] fin_code;
    int unsigned n;
    fin = FETCH; fin_code = m_code; fate = 0;
    n = (flat + 1 > T) ? T : flat + 1;
    for (int unsigned k = 0; k < n; k++) begin
      s.st = FETCH; s.resp = (flat + 1 <= T) && (k == n - 1); q.push_back(s);
    end
    if (flat + 1 > T) begin
      fin = ERR; fin_code = 2'b10;
    end else begin
      s.st = DECODE; s.resp = 0; q.push_back(s);
      if (op == OP_SYS && f3 == 3'b000) fin = HALT;
      else if (!is_legal(op) || op == OP_SYS) begin fin = ERR; fin_code = 2'b01; end
      else begin
        s.st = EXEC; s.resp = 0; q.push_back(s);
        if (op == OP_IL || op == OP_S) begin
          n = (mlat + 1 > T) ? T : mlat + 1;
          for (int unsigned k = 0; k < n; k++) begin
            s.st = MEM; s.resp = (mlat + 1 <= T) && (k == n - 1); q.push_back(s);
          end
          if (mlat + 1 > T) begin fin = ERR; fin_code = 2'b11; end
        end
        if (fin == FETCH) begin s.st = WB; s.resp = 0; q.push_back(s); end
      end
    end

    for (int i = 0; i < q.size(); i++) begin
      s = q[i];
      n_cmp++;
      if (state !== s.st) begin
        n_bad++; $display("FAIL %s[%0d] state: got %0d want %0d", nm, i, state, s.st);
      end
      n_cmp++;
      if ({ifu_req, lsu_req, lsu_wen, gpr_wen, pc_wen, halt, err} !== exp_out(s.st, op)) begin
        n_bad++;
        $display("FAIL %s[%0d] outputs(ifu,lsu,lwen,gwen,pcw,halt,err): got %b want %b", nm, i,
                 {ifu_req, lsu_req, lsu_wen, gpr_wen, pc_wen, halt, err}, exp_out(s.st, op));
      end
      n_cmp++;
      if ({cyc_cnt, instret, err_code} !== {m_cyc, m_ret, m_code}) begin
        n_bad++;
        $display("FAIL %s[%0d] counters: got cyc=%0d ret=%0d code=%b want cyc=%0d ret=%0d code=%b",
                 nm, i, cyc_cnt, instret, err_code, m_cyc, m_ret, m_code);
      end
      if (i == abort_at) begin fate = 3; return; end
      if (s.st == FETCH && !s.resp) begin
        inst_op = 7'($urandom); inst_func3 = 3'($urandom);
      end else begin
        inst_op = op; inst_func3 = f3;
      end
      ifu_valid = (s.st == FETCH) ? s.resp : ($urandom % 3 == 0);
      lsu_done  = (s.st == MEM)   ? s.resp : ($urandom % 3 == 0);
      #1;
      n_cmp++;
      if (ir_wen !== (s.st == FETCH && s.resp)) begin
        n_bad++; $display("FAIL %s[%0d] ir_wen: got %b want %b", nm, i, ir_wen, s.st == FETCH && s.resp);
      end
      @(posedge clk); #2;
      m_cyc++;
      if (s.st == WB) m_ret++;
    end
    ifu_valid = 1'b0; lsu_done = 1'b0;
    m_code = fin_code;

    if (fin != FETCH) begin
      fate = (fin == HALT) ? 1 : 2;
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if ({state, ifu_req, lsu_req, lsu_wen, gpr_wen, pc_wen, halt, err, err_code, cyc_cnt, instret}
            !== {fin, exp_out(fin, op), m_code, m_cyc, m_ret}) begin
          n_bad++;
          $display("FAIL %s terminal[%0d]: got st=%0d outs=%b code=%b cyc=%0d ret=%0d want st=%0d outs=%b code=%b cyc=%0d ret=%0d",
                   nm, c, state, {ifu_req, lsu_req, lsu_wen, gpr_wen, pc_wen, halt, err}, err_code, cyc_cnt, instret,
                   fin, exp_out(fin, op), m_code, m_cyc, m_ret);
        end
        inst_op = 7'($urandom); inst_func3 = 3'($urandom);
        ifu_valid = 1'($urandom); lsu_done = 1'($urandom);
        #1;
        n_cmp++;
        if (ir_wen !== 1'b0) begin
          n_bad++; $display("FAIL %s terminal_ir_wen: got %b want 0", nm, ir_wen);
        end
        @(posedge clk); #2;
        m_cyc++;
      end
      ifu_valid = 1'b0; lsu_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_addi();
    int f;
    exec_inst("addi", OP_I, 3'b000, 3, 0, -1, f);
  endtask

  task automatic test_lw_sw();
    int f;
    exec_inst("lw", OP_IL, 3'b010, 1, 3, -1, f);
    exec_inst("sw", OP_S, 3'b010, 0, 3, -1, f);
    exec_inst("beq", OP_B, 3'b000, 2, 0, -1, f);
  endtask

  task automatic test_back_to_back();
    int f;
    logic [6:0] ops [9];
    ops = '{OP_R, OP_I, OP_IL, OP_S, OP_B, OP_U, OP_UPC, OP_J, OP_JR};
    for (int i = 0; i < 9; i++) exec_inst("b2b", ops[i], 3'($urandom), 0, 0, -1, f);
  endtask

  task automatic test_halt();
    int f;
    exec_inst("ebreak", OP_SYS, 3'b000, 1, 0, -1, f);
    do_reset("halt_rst");
  endtask

  task automatic test_fetch_timeout();
    int f;
    exec_inst("fetch_to", OP_I, 3'b000, T, 0, -1, f);
    do_reset("fto_rst");
    exec_inst("fetch_edge", OP_R, 3'b000, T - 1, 0, -1, f);
  endtask

  task automatic test_illegal();
    int f;
    exec_inst("illegal", 7'b1111111, 3'b000, 0, 0, -1, f);
    do_reset("ill_rst");
    exec_inst("sys_f3", OP_SYS, 3'b001, 2, 0, -1, f);
    do_reset("sys_rst");
  endtask

  task automatic test_mem_timeout();
    int f;
    exec_inst("mem_edge", OP_IL, 3'b010, 0, T - 1, -1, f);
    exec_inst("mem_to", OP_S, 3'b010, 0, T, -1, f);
    do_reset("mto_rst");
  endtask

  task automatic test_reset_mid_mem();
    int f;
    exec_inst("abort_lw", OP_IL, 3'b010, 1, 3, 5, f);
    do_reset("mid_mem_rst");
    exec_inst("after_abort", OP_U, 3'b000, 0, 0, -1, f);
  endtask

  task automatic test_random();
    int f;
    logic [6:0] ops [10];
    logic [6:0] op;
    logic [2:0] f3;
    ops = '{OP_R, OP_I, OP_IL, OP_S, OP_B, OP_U, OP_UPC, OP_J, OP_JR, OP_SYS};
    for (int i = 0; i < 40; i++) begin
      op = ($urandom % 12 == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      if ($urandom % 20 == 0) op = OP_SYS;
      f3 = 3'($urandom);
      exec_inst("rand", op, f3, $urandom_range(0, T), $urandom_range(0, T), -1, f);
      if (f != 0) do_reset("rand_rst");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_addi();
    test_lw_sw();
    test_back_to_back();
    test_halt();
    test_fetch_timeout();
    do_reset("pre_illegal");
    test_illegal();
    test_mem_timeout();
    test_reset_mid_mem();
    do_reset("pre_random");
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_23060201_ctrl.md
YSYX_23060201_CTRL -- requirements
Module: ysyx_23060201_ctrl

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 255, meaning max cycles waiting in FETCH or MEM before error.
REQ-002 SHALL provide ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL provide: ifu_req  out  1  fetch request, level.
REQ-005 SHALL provide: ifu_valid  in  1  instruction available, single-cycle pulse.
REQ-006 SHALL provide: inst_op  in  7  opcode from decoder.
REQ-007 SHALL provide: inst_func3  in  3  func3 from decoder.
REQ-008 SHALL provide: ir_wen  out  1  instruction-register load strobe.
REQ-009 SHALL provide: lsu_req  out  1  memory access request, level.
REQ-010 SHALL provide: lsu_wen  out  1  access is a store.
REQ-011 SHALL provide: lsu_done  in  1  memory access complete, pulse.
REQ-012 SHALL provide: gpr_wen  out  1  register-file write enable.
REQ-013 SHALL provide: pc_wen  out  1  PC update strobe.
REQ-014 SHALL provide: halt  out  1  ebreak reached, sticky.
REQ-015 SHALL provide: err  out  1  fault, sticky; err_code  out  2  01 illegal op, 10 fetch timeout, 11 LSU timeout.
REQ-016 SHALL provide: state  out  3  current state; cyc_cnt  out  32  cycle counter; instret  out  32  retired count.

Function
REQ-017 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
REQ-018 Legal opcodes: R 0110011, I 0010011, IL 0000011, S 0100011, B 1100011, U 0110111, UPC 0010111, J 1101111, JR 1100111, SYS 1110011.
REQ-019 IDLE -> FETCH unconditionally after one cycle.
REQ-020 FETCH: ifu_req=1; on ifu_valid -> ir_wen=1 same cycle (combinational), next state DECODE.
REQ-021 DECODE: SYS with func3=000 -> HALT; opcode outside REQ-018 or SYS with func3!=000 -> ERR, err_code=01; else -> EXEC.
REQ-022 EXEC: IL or S -> MEM; all others -> WB; one cycle.
REQ-023 MEM: lsu_req=1, lsu_wen=1 only for S; on lsu_done -> WB.
REQ-024 WB: pc_wen=1 one cycle; gpr_wen=1 for R, I, IL, U, UPC, J, JR; gpr_wen=0 for S, B; instret +1; -> FETCH.
REQ-025 inst_op/inst_func3 sampled in DECODE, EXEC, WB assume stable from the loaded instruction register; block holds no copy.
REQ-026 Wait counter cleared on entry to FETCH/MEM, +1 per waiting cycle; count reaching MEM_TIMEOUT without response -> ERR, code 10 (FETCH) or 11 (MEM).
REQ-027 Response in the same cycle the counter reaches MEM_TIMEOUT: response wins, no error.
REQ-028 ifu_valid outside FETCH, lsu_done outside MEM: ignored, no state or counter effect.
REQ-029 HALT, ERR: terminal until rst; all strobes/requests 0; halt=1 (HALT) or err=1 (ERR); err_code held.
REQ-030 cyc_cnt +1 every non-reset cycle incl. HALT/ERR; cyc_cnt and instret wrap 0xFFFFFFFF -> 0.
REQ-031 ifu_req, lsu_req, lsu_wen, gpr_wen, pc_wen SHALL be decoded from state only (Moore); ir_wen sole Mealy output.
REQ-032 At most one of ifu_req, lsu_req, pc_wen asserted in any cycle.

Reset
REQ-033 rst=1 at any edge, any state (incl. mid-MEM): state=IDLE, cyc_cnt=0, instret=0, wait counter=0, halt=0, err=0, err_code=00, all requests/strobes 0.
REQ-034 Responses arriving while rst=1 ignored; first fetch request appears in cycle 2 after rst falls (IDLE, then FETCH).

Verification
REQ-035 ADDI (op 0010011), ifu_valid 3 cycles after ifu_req -> ir_wen pulse, DECODE, EXEC, WB with gpr_wen=1,pc_wen=1, instret=1.
REQ-036 LW (0000011), lsu_done after 4 cycles -> lsu_req high 4 cycles, lsu_wen=0, gpr_wen=1 in WB; SW (0100011) -> lsu_wen=1, gpr_wen=0.
REQ-037 op 1110011 func3=000 -> HALT, halt=1, ifu_req=0 forever; instret unchanged; cyc_cnt keeps counting.
REQ-038 MEM_TIMEOUT=4, no ifu_valid -> ERR, err_code=10; repeat with ifu_valid on 4th wait cycle -> DECODE, err=0.
REQ-039 op 1111111 -> ERR, err_code=01; rst asserted in MEM mid-access -> all outputs reset values next cycle, FETCH 2 cycles after release.
